// File: rtl/comp32_sched_pkg.sv
// comp32_sched shared types and constants.
// FSM encoding, counter width and id width helper.
package comp32_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int CNT_W = 3;

  function automatic int ID_W(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/comp32_sched_rr_pick.sv
// Combinational round-robin picker.
// Searches upward from last+1, wrapping at NREQ.
module rr_pick
  import comp32_sched_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int IW   = ID_W(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx
);

  logic found;
  int   j;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 1; k <= NREQ; k++) begin
      j = (int'(last) + k) % NREQ;
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/comp32_sched.sv
// Round-robin scheduler sharing one comp32 between requesters.
// One transaction in flight: accept, wait out latency, respond.
module comp32_sched
  import comp32_sched_pkg::*;
#(
  parameter  int NREQ    = 4,
  parameter  int W       = 32,
  parameter  int CMP_LAT = 1,
  localparam int IW      = ID_W(NREQ)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req_valid,
  output logic [NREQ-1:0] req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic [NREQ-1:0] rsp_valid,
  output logic            rsp_z,
  input  logic [NREQ-1:0] rsp_ready,
  output logic [W-1:0]    cmp_a,
  output logic [W-1:0]    cmp_b,
  input  logic            cmp_z,
  output logic            busy,
  output logic [IW-1:0]   grant_id
);

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] cnt;
  logic [IW-1:0]    last_grant;
  logic [NREQ-1:0]  pick;
  logic [IW-1:0]    pick_id;
  logic             accept;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req  (req_valid),
    .last (last_grant),
    .gnt  (pick),
    .idx  (pick_id)
  );

  assign req_ready = (state == IDLE && !rst) ? pick : '0;
  assign accept    = |req_ready;
  assign busy      = (state != IDLE);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (accept) state_nx = WAIT;
      WAIT: if (cnt == '0) state_nx = RESP;
      RESP: if (rsp_ready[grant_id]) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      cmp_a      <= '0;
      cmp_b      <= '0;
      rsp_z      <= 1'b0;
      rsp_valid  <= '0;
      grant_id   <= '0;
      last_grant <= IW'(NREQ - 1);
    end else begin
      state <= state_nx;
      unique case (state)
        IDLE: if (accept) begin
          cmp_a    <= req_a[int'(pick_id)*W +: W];
          cmp_b    <= req_b[int'(pick_id)*W +: W];
          grant_id <= pick_id;
          cnt      <= CNT_W'(CMP_LAT);
        end
        // cmp_z is only trusted once the latency has fully elapsed
        WAIT: if (cnt == '0) begin
          rsp_z     <= cmp_z;
          rsp_valid <= NREQ'(1) << grant_id;
        end else begin
          cnt <= cnt - 1'b1;
        end
        RESP: if (rsp_ready[grant_id]) begin
          rsp_valid  <= '0;
          last_grant <= grant_id;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_comp32_sched.sv
// Self-checking bench for comp32_sched with behavioural comp32 models.
// Directed and random transactions against a round-robin reference.
module tb_comp32_sched;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_valid, req_ready, rsp_valid, rsp_ready;
  logic [127:0] req_a, req_b;
  logic [31:0]  cmp_a, cmp_b;
  logic         cmp_z, rsp_z, busy;
  logic [1:0]   grant_id;

  logic         rst3;
  logic [3:0]   req_valid3, req_ready3, rsp_valid3, rsp_ready3;
  logic [127:0] req_a3, req_b3;
  logic [31:0]  cmp_a3, cmp_b3;
  logic         cmp_z3, rsp_z3, busy3;
  logic [1:0]   grant_id3;
  logic [2:0]   pipe3;
  logic         force_on, force_val;

  int passes = 0;
  int total  = 0;
  int cyc    = 0;
  int last   = 3;
  int last3  = 3;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  comp32_sched #(.NREQ(4), .W(32), .CMP_LAT(1)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_z(rsp_z), .rsp_ready(rsp_ready),
    .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_z(cmp_z),
    .busy(busy), .grant_id(grant_id)
  );

  comp32_sched #(.NREQ(4), .W(32), .CMP_LAT(3)) dut3 (
    .clk(clk), .rst(rst3),
    .req_valid(req_valid3), .req_ready(req_ready3),
    .req_a(req_a3), .req_b(req_b3),
    .rsp_valid(rsp_valid3), .rsp_z(rsp_z3), .rsp_ready(rsp_ready3),
    .cmp_a(cmp_a3), .cmp_b(cmp_b3), .cmp_z(cmp_z3),
    .busy(busy3), .grant_id(grant_id3)
  );

  // comp32 models: registered equality, latency 1 and 3
  always_ff @(posedge clk) cmp_z <= (cmp_a == cmp_b);
  always_ff @(posedge clk) pipe3 <= {pipe3[1:0], cmp_a3 == cmp_b3};
  assign cmp_z3 = force_on ? force_val : pipe3[2];

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic int rr_expect(input logic [3:0] v, input int lg);
    for (int k = 1; k <= 4; k++) begin
      int j;
      j = (lg + k) % 4;
      if (v[j]) return j;
    end
    return -1;
  endfunction

  task automatic serve(input logic [3:0] v, input logic [31:0] a,
                       input logic [31:0] b, input int hold,
                       output int g, output int acc);
    logic [3:0] oh;
    g  = rr_expect(v, last);
    oh = 4'b0001 << g;
    for (int k = 0; k < 4; k++) begin
      req_a[k*32 +: 32] = $urandom;
      req_b[k*32 +: 32] = $urandom;
    end
    req_a[g*32 +: 32] = a;
    req_b[g*32 +: 32] = b;
    req_valid = v;
    rsp_ready = 4'h0;
    #1;
    acc = cyc;
    chk("accept_ready", req_ready, oh);
    @(negedge clk);
    chk("cmp_a", cmp_a, a);
    chk("cmp_b", cmp_b, b);
    chk("grant_id", grant_id, g);
    chk("busy_wait", busy, 1);
    chk("ready_in_wait", req_ready, 0);
    @(negedge clk);
    chk("no_early_rsp", rsp_valid, 0);
    @(negedge clk);
    rsp_ready = (hold > 0) ? ~oh : oh;
    #1;
    chk("rsp_valid", rsp_valid, oh);
    chk("rsp_z", rsp_z, a == b);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("rsp_valid_hold", rsp_valid, oh);
      chk("rsp_z_hold", rsp_z, a == b);
    end
    rsp_ready = oh;
    @(negedge clk);
    chk("back_idle", busy, 0);
    chk("rsp_dropped", rsp_valid, 0);
    last = g;
  endtask

  task automatic serve3(input logic [3:0] v, input logic [31:0] a,
                        input logic [31:0] b);
    logic [3:0] oh;
    int         g;
    g  = rr_expect(v, last3);
    oh = 4'b0001 << g;
    req_a3 = {4{$urandom}};
    req_b3 = {4{$urandom}};
    req_a3[g*32 +: 32] = a;
    req_b3[g*32 +: 32] = b;
    req_valid3 = v;
    rsp_ready3 = oh;
    #1;
    chk("l3_accept", req_ready3, oh);
    for (int t = 1; t <= 4; t++) begin
      @(negedge clk);
      force_on  = (t < 4);
      force_val = (t == 2) ? 1'($urandom) : (a != b);
      chk("l3_no_rsp", rsp_valid3, 0);
    end
    @(negedge clk);
    force_on  = 1'b1;
    force_val = (a != b);
    chk("l3_rsp_valid", rsp_valid3, oh);
    chk("l3_rsp_z", rsp_z3, a == b);
    chk("l3_grant", grant_id3, g);
    @(negedge clk);
    force_on = 1'b0;
    chk("l3_idle", busy3, 0);
    last3 = g;
  endtask

  initial begin
    int g, acc, prev;
    logic [31:0] a, b;
    logic [3:0]  v;
    rst = 1'b1; rst3 = 1'b1;
    req_valid = 4'hF; rsp_ready = 4'h0;
    req_a = '0; req_b = '0;
    req_valid3 = 4'h0; rsp_ready3 = 4'h0;
    req_a3 = '0; req_b3 = '0;
    force_on = 1'b0; force_val = 1'b0;

    @(negedge clk);
    chk("rst_ready", req_ready, 0);
    @(negedge clk);
    chk("rst_ready2", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cmp_a", cmp_a, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_rsp_z", rsp_z, 0);
    rst = 1'b0;
    last = 3;

    prev = 0;
    for (int i = 0; i < 5; i++) begin
      a = $urandom;
      b = a;
      if (i % 2 == 1) begin
        a = 32'hFFFF_FFFF;
        b = 32'h0;
      end
      serve(4'hF, a, b, 0, g, acc);
      chk("rr_order", grant_id, i % 4);
      if (i > 0) chk("rr_gap", acc - prev, 4);
      prev = acc;
    end

    serve(4'b1000, $urandom, $urandom, 0, g, acc);
    chk("wrap_3", grant_id, 3);
    serve(4'b1010, 32'h55, 32'h55, 0, g, acc);
    chk("wrap_1", grant_id, 1);
    serve(4'b1010, 32'h55, 32'h56, 0, g, acc);
    chk("wrap_3b", grant_id, 3);
    serve(4'b0010, 32'h7, 32'h7, 0, g, acc);
    serve(4'b0010, 32'h8, 32'h9, 0, g, acc);
    chk("solo_1", grant_id, 1);

    serve(4'b0100, 32'h0000_1234, 32'h0000_1234, 5, g, acc);
    chk("single_2", grant_id, 2);

    for (int i = 0; i < 8; i++) begin
      v = 4'($urandom_range(1, 15));
      a = $urandom;
      b = ($urandom_range(0, 1) == 1) ? a : $urandom;
      serve(v, a, b, $urandom_range(0, 2), g, acc);
    end

    req_valid = 4'h0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_busy", busy, 0);
      chk("idle_ready", req_ready, 0);
    end

    req_a[96 +: 32] = $urandom;
    req_b[96 +: 32] = $urandom;
    req_valid = 4'b1000;
    #1;
    chk("abort_accept", req_ready, 4'b1000);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    req_valid = 4'h0;
    @(negedge clk);
    rst = 1'b0;
    last = 3;
    chk("abort_busy", busy, 0);
    chk("abort_rsp", rsp_valid, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort_no_rsp", rsp_valid, 0);
    end
    serve(4'b1000, 32'hCAFE, 32'hCAFE, 0, g, acc);
    chk("after_abort_3", grant_id, 3);

    rst3 = 1'b0;
    chk("l3_rst_busy", busy3, 0);
    chk("l3_rst_rsp", rsp_valid3, 0);
    a = $urandom;
    serve3(4'b0001, a, a);
    serve3(4'b0011, 32'hFFFF_FFFF, 32'h0);
    a = $urandom;
    serve3(4'b0110, a, a ^ 32'h0001_0000);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/comp32_sched.md
Name: comp32_sched

Overview:
- Round-robin scheduler that shares one comp32 comparator instance between NREQ requesters.
- Accepts an operand pair from one requester at a time and drives it onto the comparator.
- Waits out the comparator latency, samples z, and returns the result to the granted requester over a valid/ready response channel.
- Sits between requester logic and comp32 in the comp32 subsystem top. comp32 stays a separate instance so its SDF annotation is unaffected.

Parameters:
- NREQ, 4, number of requesters (2..8).
- W, 32, operand width; must match comp32.
- CMP_LAT, 1, comparator register latency in cycles (1..7); comp32 as built is 1.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  NREQ  request strobe per requester.
- req_ready  out  NREQ  one-hot accept; zero or one bit set.
- req_a  in  NREQ*W  operand a; requester i at [i*W +: W].
- req_b  in  NREQ*W  operand b; same packing.
- rsp_valid  out  NREQ  one-hot result strobe.
- rsp_z  out  1  result bit, qualified by rsp_valid.
- rsp_ready  in  NREQ  result accept per requester.
- cmp_a  out  W  registered operand a to comp32.
- cmp_b  out  W  registered operand b to comp32.
- cmp_z  in  1  comp32 output.
- busy  out  1  high in any state other than IDLE.
- grant_id  out  max(1,$clog2(NREQ))  index of current or last granted requester.

Behaviour:
- Reset values (rst high at an edge):
  - State goes to IDLE.
  - cmp_a=0, cmp_b=0, rsp_z=0, rsp_valid=0, grant_id=0, busy=0.
  - last_grant=NREQ-1, so requester 0 wins first.
  - req_ready is forced 0 while rst is high.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready is combinational: a one-hot pick of req_valid.
  - Search order is (last_grant+1) mod NREQ upward, wrapping.
  - Accept = req_valid[i] & req_ready[i] in cycle T.
  - At the end of T: cmp_a/cmp_b <= req_a/req_b slice i, grant_id <= i, cnt <= CMP_LAT, go to WAIT.
  - No valid requests: stay in IDLE, all outputs held.
- WAIT:
  - Lasts CMP_LAT+1 cycles (T+1 .. T+CMP_LAT+1); cnt decrements each cycle.
  - In the cycle with cnt==0: rsp_z <= cmp_z, go to RESP.
  - cmp_z is ignored at all other times.
- RESP (from T+CMP_LAT+2):
  - rsp_valid[grant_id]=1; rsp_z is stable.
  - On rsp_ready[grant_id]=1: rsp_valid <= 0, last_grant <= grant_id, go to IDLE.
  - rsp_ready bits of non-granted requesters are ignored.
- Throughput: one compare per CMP_LAT+3 cycles with rsp_ready held high. There is no back-to-back overlap; req_ready is only possible in IDLE.
- cmp_a/cmp_b hold their values through WAIT, RESP and IDLE until the next accept.
- Requesters keep req_a/req_b stable while req_valid is high. The block samples operands only in the accept cycle.
- A request withdrawn before accept is legal and is simply not granted.
- rst during WAIT or RESP aborts the transaction: no rsp_valid is issued, and arbitration restarts at requester 0.
- NREQ=1 degenerates to a fixed grant; the round-robin logic must still elaborate.

Decomposition:
- Package comp32_sched_pkg holds:
  - the FSM state typedef (IDLE/WAIT/RESP, 2-bit encoding);
  - the CNT_W constant (3 bits, covers CMP_LAT up to 7);
  - the ID_W helper function.
- Sub-module rr_pick (parameter NREQ) is natural: purely combinational. Inputs are the req vector and last_grant; outputs are the one-hot grant and the encoded index.
- comp32 itself is instantiated in the subsystem top, not inside comp32_sched.

Test Plan:
- The bench comp32 model registers z=(a==b), latency CMP_LAT.
- Reset: rst high for 2 cycles with req_valid=4'b1111 -> req_ready=0, rsp_valid=0, busy=0, cmp_a=0, grant_id=0; first grant after release goes to requester 0.
- Single request: requester 2 with a=b=0x0000_1234, accepted at T -> cmp_a=0x1234 at T+1, rsp_valid=4'b0100 and rsp_z=1 at T+3. Hold rsp_ready=0 for 5 cycles -> rsp_valid and rsp_z stay stable. rsp_ready[0]=1 during that window -> ignored.
- Round robin: req_valid=4'b1111 continuously, rsp_ready=4'b1111 -> grant order 0,1,2,3,0. Accepts are exactly 4 cycles apart. Alternating a=b and a=0xFFFF_FFFF,b=0 -> rsp_z sequence 1,0,1,0,1.
- Wrap fairness: after a grant to 3, req_valid=4'b1010 -> grant 1, then 3. After a grant to 1 with only requester 1 valid -> grant 1 again.
- Latency build with CMP_LAT=3: the model toggles z during early WAIT cycles -> rsp_valid at T+5, and rsp_z equals the model value at the final WAIT cycle only.
- Reset mid-operation: rst pulsed at T+2 of a requester-3 transaction -> no rsp_valid is ever raised for it. With req_valid=4'b1000 after reset -> requester 3 is accepted and completes normally.
